apac_keypad_entry: RTL and testbench
====================================

# apac_keypad_entry

Keypad front-end for the automatic parking access controller. Collects two BCD digit presses from the entrance keypad into an 8-bit attempt, then presents it on `psswrd_atmpt` with a `try_psswrd` strobe of fixed length. Sits directly upstream of the access-control FSM and drives its `psswrd_atmpt`/`try_psswrd` inputs. Handles clear, premature enter and inactivity timeout so the FSM only ever sees complete, stable attempts.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles after the last accepted key before a partial entry is discarded; must be ≥ 2.
- `TRY_HOLD`, default 2: number of cycles `try_psswrd` stays high per submission; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  entry allowed; tied to the entrance sensor (`sensor_1`) path.
- `key_valid`  in  1  keypad key-down level; one press = one rising edge.
- `key_code`  in  4  0x0–0x9 digit, 0xA clear, 0xB enter, 0xC–0xF ignored.
- `psswrd_atmpt`  out  8  submitted attempt, {first digit, second digit}.
- `try_psswrd`  out  1  verify strobe for the downstream FSM.
- `digit_count`  out  2  digits currently buffered (0, 1, 2).
- `entry_err`  out  1  one-cycle pulse on a rejected key.
- `entry_timeout`  out  1  one-cycle pulse when a partial entry is discarded.

## Operation
- Key event = `key_valid` high and registered `key_valid_q` low; `key_code` is sampled on the same edge. Events are ignored while `enable`=0 and in SUBMIT.
- States: IDLE (0 digits), ONE (1), TWO (2), SUBMIT.
- IDLE + digit d: high nibble ← d, go to ONE. ONE + digit d: low nibble ← d, go to TWO. TWO + digit: ignored, `entry_err` pulses, stays in TWO.
- Enter in TWO: `psswrd_atmpt` ← buffer, go to SUBMIT. Enter in IDLE/ONE: `entry_err` pulses, buffer cleared, go to IDLE.
- Clear in IDLE/ONE/TWO: buffer cleared, go to IDLE, no error.
- Codes 0xC–0xF: no effect and no error.
- SUBMIT: `try_psswrd`=1 for exactly TRY_HOLD cycles, then IDLE with the buffer cleared. SUBMIT always completes; it is not aborted by `enable`.
- `enable` falling while in ONE/TWO: next edge goes to IDLE and clears the buffer, with no error or timeout pulse.
- Timeout: the idle counter resets on every accepted event and on entry to ONE. In ONE/TWO, after TIMEOUT_CYCLES cycles without an accepted event: go to IDLE, clear the buffer, pulse `entry_timeout`.
- A key event in the same cycle as timeout expiry: the key wins and the counter restarts.
- `psswrd_atmpt` changes only on a submit and holds between submits.

## Timing
- Reset values: `psswrd_atmpt`=8'h00, `try_psswrd`=0, `digit_count`=0, `entry_err`=0, `entry_timeout`=0, `key_valid_q`=0, state IDLE.
- Reset mid-operation, including during SUBMIT, returns to IDLE immediately and drops `try_psswrd` asynchronously.
- All outputs are registered.
- Latency: the event edge E updates state and `digit_count` at E. For enter at E, `psswrd_atmpt` is valid from E and `try_psswrd` is high during cycles E..E+TRY_HOLD−1. IDLE is reached at E+TRY_HOLD.
- `psswrd_atmpt` is stable for the whole `try_psswrd` window and after it.
- Back-to-back presses need `key_valid` low for ≥1 sampled cycle between them.

## Structure
- The shared package `apac_pkg` holds:
  - the state enum (IDLE, ONE, TWO, SUBMIT);
  - `KEY_CLEAR`=4'hA and `KEY_ENTER`=4'hB;
  - the 8-bit attempt width constant, shared with the access-control FSM.
- Sub-module `apac_idle_timer`: a $clog2(TIMEOUT_CYCLES)-bit counter with `restart`, `run` and a one-cycle `expired` output. The FSM and the edge detector stay in the top module.

## Test plan
- Reset, `enable`=1, keys 5, 7, enter → `psswrd_atmpt`=8'h57 and `try_psswrd` high for exactly 2 cycles starting on the enter edge; `digit_count` goes 0→1→2→0.
- Keys 5, enter → `entry_err` pulses once, no `try_psswrd`, `digit_count`=0, previous `psswrd_atmpt` unchanged.
- Keys 1, 2, 3 → `entry_err` on the third key; enter → `psswrd_atmpt`=8'h12.
- Key 4 then 1000 idle cycles → `entry_timeout` pulses on cycle 1000, `digit_count`=0. Repeat with a key 9 on the expiry cycle → no timeout, `digit_count`=2.
- Keys 3, clear, 8, 8, enter → `psswrd_atmpt`=8'h88. Same sequence with `enable` dropped after the first 8 → buffer cleared, no strobe.
- Assert `rst` during the `try_psswrd` window → `try_psswrd` drops immediately, all outputs take reset values, and keys held high through reset release generate no event.

Source files
------------

// File: rtl/apac_pkg.sv
// rtl/apac_pkg.sv - shared types and constants for the parking access keypad path
package apac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ONE,
    ST_TWO,
    ST_SUBMIT
  } entry_state_t;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam int         ATTEMPT_W = 8;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'h9;
  endfunction

endpackage

// File: rtl/apac_keypad_entry_if.sv
// rtl/apac_keypad_entry_if.sv - keypad input and attempt output bundle
interface apac_keypad_entry_if;
  import apac_pkg::*;

  logic                 enable;
  logic                 key_valid;
  logic [3:0]           key_code;
  logic [ATTEMPT_W-1:0] psswrd_atmpt;
  logic                 try_psswrd;
  logic [1:0]           digit_count;
  logic                 entry_err;
  logic                 entry_timeout;

  modport master (
    output enable, key_valid, key_code,
    input  psswrd_atmpt, try_psswrd, digit_count, entry_err, entry_timeout
  );

  modport slave (
    input  enable, key_valid, key_code,
    output psswrd_atmpt, try_psswrd, digit_count, entry_err, entry_timeout
  );
endinterface

// File: rtl/apac_idle_timer.sv
// rtl/apac_idle_timer.sv - inactivity counter that flags the last idle cycle of a partial entry
module apac_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic run,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // A restart in the expiry cycle suppresses the flag so a late key wins.
  assign expired = run && !restart && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || !run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/apac_keypad_entry.sv
// rtl/apac_keypad_entry.sv - collects two BCD key presses and strobes a fixed-length verify request
module apac_keypad_entry
  import apac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TRY_HOLD       = 2
) (
  input  logic                clk,
  input  logic                rst,
  apac_keypad_entry_if.slave  bus
);
  localparam int HOLD_W = $clog2(TRY_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TRY_HOLD - 1);

  entry_state_t         state, nxt;
  logic                 key_valid_q;
  logic                 armed;
  logic [ATTEMPT_W-1:0] entry_buf, buf_nxt;
  logic [ATTEMPT_W-1:0] atmpt_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic                 err_nxt, timeout_nxt;
  logic                 key_event, accepted, run, expired;

  // armed stays low until key_valid is seen low, so a key held through reset is not a press.
  assign key_event = bus.key_valid && !key_valid_q && armed;
  assign accepted  = key_event && bus.enable && (state != ST_SUBMIT) && (bus.key_code <= KEY_ENTER);
  assign run       = (state == ST_ONE) || (state == ST_TWO);

  apac_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(accepted),
    .run    (run),
    .expired(expired)
  );

  always_comb begin
    nxt         = state;
    buf_nxt     = entry_buf;
    atmpt_nxt   = bus.psswrd_atmpt;
    hold_nxt    = hold_cnt;
    err_nxt     = 1'b0;
    timeout_nxt = 1'b0;
    if (state == ST_SUBMIT) begin
      if (hold_cnt == HOLD_LAST) begin
        nxt      = ST_IDLE;
        buf_nxt  = '0;
        hold_nxt = '0;
      end else begin
        hold_nxt = hold_cnt + HOLD_W'(1);
      end
    end else if (!bus.enable) begin
      nxt     = ST_IDLE;
      buf_nxt = '0;
    end else if (accepted) begin
      if (is_digit(bus.key_code)) begin
        case (state)
          ST_IDLE: begin
            buf_nxt[7:4] = bus.key_code;
            nxt          = ST_ONE;
          end
          ST_ONE: begin
            buf_nxt[3:0] = bus.key_code;
            nxt          = ST_TWO;
          end
          default: err_nxt = 1'b1;
        endcase
      end else if (bus.key_code == KEY_CLEAR) begin
        nxt     = ST_IDLE;
        buf_nxt = '0;
      end else if (state == ST_TWO) begin
        atmpt_nxt = entry_buf;
        hold_nxt  = '0;
        nxt       = ST_SUBMIT;
      end else begin
        err_nxt = 1'b1;
        nxt     = ST_IDLE;
        buf_nxt = '0;
      end
    end else if (expired) begin
      timeout_nxt = 1'b1;
      nxt         = ST_IDLE;
      buf_nxt     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_IDLE;
      key_valid_q       <= 1'b0;
      armed             <= 1'b0;
      entry_buf         <= '0;
      hold_cnt          <= '0;
      bus.psswrd_atmpt  <= '0;
      bus.try_psswrd    <= 1'b0;
      bus.digit_count   <= 2'd0;
      bus.entry_err     <= 1'b0;
      bus.entry_timeout <= 1'b0;
    end else begin
      state             <= nxt;
      key_valid_q       <= bus.key_valid;
      armed             <= armed | !bus.key_valid;
      entry_buf         <= buf_nxt;
      hold_cnt          <= hold_nxt;
      bus.psswrd_atmpt  <= atmpt_nxt;
      bus.try_psswrd    <= (nxt == ST_SUBMIT);
      bus.digit_count   <= (nxt == ST_ONE) ? 2'd1 : (nxt == ST_TWO) ? 2'd2 : 2'd0;
      bus.entry_err     <= err_nxt;
      bus.entry_timeout <= timeout_nxt;
    end
  end
endmodule

// File: tb/tb_apac_keypad_entry.sv
// tb/tb_apac_keypad_entry.sv - directed and random checks of the keypad entry block against a queue model
module tb_apac_keypad_entry;
  localparam int TO = 1000;
  localparam int TH = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apac_keypad_entry_if bus();

  apac_keypad_entry #(
    .TIMEOUT_CYCLES(TO),
    .TRY_HOLD      (TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  logic [3:0] m_digits[$];
  logic [7:0] m_atmpt;
  int         m_left;
  int         m_idle;
  bit         m_prev, m_armed, m_err, m_to;

  function automatic void m_reset();
    m_digits.delete();
    m_atmpt = 8'h00;
    m_left  = 0;
    m_idle  = 0;
    m_prev  = 0;
    m_armed = 0;
    m_err   = 0;
    m_to    = 0;
  endfunction

  // One rising edge of the intended behaviour, using the inputs currently applied.
  function automatic void m_step();
    bit ev;
    ev = bus.key_valid && !m_prev && m_armed;
    m_prev = bus.key_valid;
    if (!bus.key_valid) m_armed = 1;
    m_err = 0;
    m_to  = 0;
    if (m_left > 0) begin
      m_left--;
    end else if (!bus.enable) begin
      m_digits.delete();
    end else if (ev && bus.key_code <= 4'hB) begin
      m_idle = 0;
      if (bus.key_code <= 4'h9) begin
        if (m_digits.size() < 2) m_digits.push_back(bus.key_code);
        else m_err = 1;
      end else if (bus.key_code == 4'hA) begin
        m_digits.delete();
      end else begin
        if (m_digits.size() == 2) begin
          m_atmpt = {m_digits[0], m_digits[1]};
          m_left  = TH;
        end else begin
          m_err = 1;
        end
        m_digits.delete();
      end
    end else if (m_digits.size() > 0) begin
      m_idle++;
      if (m_idle >= TO) begin
        m_to = 1;
        m_digits.delete();
        m_idle = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    logic [1:0] dc_exp;
    dc_exp = (m_left > 0) ? 2'd0 : 2'(m_digits.size());
    total++;
    assert (bus.try_psswrd === (m_left > 0)) else begin
      bad++; $error("FAIL try_psswrd got=%0b exp=%0b t=%0t", bus.try_psswrd, (m_left > 0), $time);
    end
    total++;
    assert (bus.psswrd_atmpt === m_atmpt) else begin
      bad++; $error("FAIL psswrd_atmpt got=%h exp=%h t=%0t", bus.psswrd_atmpt, m_atmpt, $time);
    end
    total++;
    assert (bus.digit_count === dc_exp) else begin
      bad++; $error("FAIL digit_count got=%0d exp=%0d t=%0t", bus.digit_count, dc_exp, $time);
    end
    total++;
    assert (bus.entry_err === m_err) else begin
      bad++; $error("FAIL entry_err got=%0b exp=%0b t=%0t", bus.entry_err, m_err, $time);
    end
    total++;
    assert (bus.entry_timeout === m_to) else begin
      bad++; $error("FAIL entry_timeout got=%0b exp=%0b t=%0t", bus.entry_timeout, m_to, $time);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic press(input logic [3:0] code, input int gap);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check_val("reset_atmpt", bus.psswrd_atmpt, 8'h00);
    rst = 1'b0;
    bus.enable = 1'b1;
    tick();

    // 5, 7, enter
    press(4'h5, 1);
    check_val("dc_one", {6'd0, bus.digit_count}, 8'd1);
    press(4'h7, 1);
    check_val("dc_two", {6'd0, bus.digit_count}, 8'd2);
    bus.key_valid = 1'b1; bus.key_code = 4'hB;
    tick();
    check_val("atmpt_57", bus.psswrd_atmpt, 8'h57);
    check_val("try_e0", {7'd0, bus.try_psswrd}, 8'd1);
    bus.key_valid = 1'b0;
    tick();
    check_val("try_e1", {7'd0, bus.try_psswrd}, 8'd1);
    tick();
    check_val("try_e2", {7'd0, bus.try_psswrd}, 8'd0);
    check_val("dc_after_submit", {6'd0, bus.digit_count}, 8'd0);

    // premature enter
    press(4'h5, 1);
    bus.key_valid = 1'b1; bus.key_code = 4'hB;
    tick();
    check_val("err_premature", {7'd0, bus.entry_err}, 8'd1);
    bus.key_valid = 1'b0;
    tick();
    check_val("atmpt_kept", bus.psswrd_atmpt, 8'h57);

    // third digit rejected
    press(4'h1, 1);
    press(4'h2, 1);
    bus.key_valid = 1'b1; bus.key_code = 4'h3;
    tick();
    check_val("err_third", {7'd0, bus.entry_err}, 8'd1);
    bus.key_valid = 1'b0;
    tick();
    press(4'hB, 3);
    check_val("atmpt_12", bus.psswrd_atmpt, 8'h12);

    // timeout, then a key landing exactly on the expiry cycle
    press(4'h4, TO - 1);
    check_val("to_early", {7'd0, bus.entry_timeout}, 8'd0);
    tick();
    check_val("to_pulse", {7'd0, bus.entry_timeout}, 8'd1);
    check_val("to_dc", {6'd0, bus.digit_count}, 8'd0);
    tick();
    press(4'h4, TO - 1);
    bus.key_valid = 1'b1; bus.key_code = 4'h9;
    tick();
    check_val("race_to", {7'd0, bus.entry_timeout}, 8'd0);
    check_val("race_dc", {6'd0, bus.digit_count}, 8'd2);
    bus.key_valid = 1'b0;
    tick();
    press(4'hA, 1);

    // clear then 8, 8, enter; then the same with enable dropped
    press(4'h3, 1); press(4'hA, 1); press(4'h8, 1); press(4'h8, 1); press(4'hB, 3);
    check_val("atmpt_88", bus.psswrd_atmpt, 8'h88);
    press(4'h3, 1); press(4'hA, 1); press(4'h8, 1);
    bus.enable = 1'b0;
    tick();
    check_val("dis_dc", {6'd0, bus.digit_count}, 8'd0);
    press(4'h8, 1); press(4'hB, 3);
    check_val("dis_atmpt", bus.psswrd_atmpt, 8'h88);
    bus.enable = 1'b1;
    tick();

    // reset during the try window with a key held through release
    press(4'h5, 1); press(4'h7, 1);
    bus.key_valid = 1'b1; bus.key_code = 4'hB;
    tick();
    check_val("pre_rst_try", {7'd0, bus.try_psswrd}, 8'd1);
    #2 rst = 1'b1;
    bus.key_code = 4'h5;
    #1;
    m_reset();
    check_outputs();
    check_val("rst_try_drop", {7'd0, bus.try_psswrd}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    check_val("held_no_event", {6'd0, bus.digit_count}, 8'd0);
    bus.key_valid = 1'b0;
    tick();
    press(4'h6, 1);
    check_val("after_rst_dc", {6'd0, bus.digit_count}, 8'd1);
    press(4'hA, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [3:0] code;
      r = $urandom_range(0, 99);
      if (r < 60) code = 4'($urandom_range(0, 9));
      else if (r < 70) code = 4'hA;
      else if (r < 90) code = 4'hB;
      else code = 4'($urandom_range(12, 15));
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.key_valid = 1'b1;
      bus.key_code = code;
      repeat ($urandom_range(1, 2)) tick();
      bus.key_valid = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
